// File: rtl/icache_ctrl.sv
// Blocking 4-way set-associative instruction cache controller: 8 sets, 32-byte lines,
// single outstanding fetch, line refill from memory with pointer-based replacement.
module icache_ctrl #(
  parameter int TAG_W = 24,
  parameter int IDX_W = 3,
  parameter int WAYS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
);
  localparam int SETS  = 1 << IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, HIT_RSP, MISS_REQ, REFILL, MISS_RSP
  } state_t;

  state_t           state_q, state_d;
  logic [31:2]      addr_q, addr_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WAY_W-1:0] vic_q, vic_d;
  logic             vic_ptr_q, vic_ptr_d;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [WAY_W-1:0] vptr_q [SETS];
  logic [WAY_W-1:0] vptr_d [SETS];
  logic [31:0]      beat_buf_q [8];
  logic [31:0]      beat_buf_d [8];

  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [255:0]     data_mem [WAYS][SETS];

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic             hit, has_inv;
  logic [WAY_W-1:0] hit_way, inv_way;
  logic [255:0]     hit_line, line;
  logic             commit;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^from_cpu_inst_req_addr[1:0];

  assign tag = addr_q[31:32-TAG_W];
  assign idx = addr_q[5+IDX_W-1:5];
  assign off = addr_q[4:2];

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit_line = data_mem[hit_way][idx];

  // Line as committed: buffered words with the in-flight beat merged in.
  always_comb begin
    line = '0;
    for (int i = 0; i < 8; i++) begin
      line[32*i +: 32] = (3'(i) == cnt_q) ? from_mem_rd_rsp_data : beat_buf_q[i];
    end
  end

  assign commit = (state_q == REFILL) && from_mem_rd_rsp_valid && from_mem_rd_rsp_last && !rst;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    vic_d      = vic_q;
    vic_ptr_d  = vic_ptr_q;
    valid_d    = valid_q;
    vptr_d     = vptr_q;
    beat_buf_d = beat_buf_q;
    case (state_q)
      IDLE: begin
        if (from_cpu_inst_req_valid) begin
          addr_d  = from_cpu_inst_req_addr[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_data_d = hit_line[{off, 5'b0} +: 32];
          state_d    = HIT_RSP;
        end else begin
          vic_d     = has_inv ? inv_way : vptr_q[idx];
          vic_ptr_d = !has_inv;
          state_d   = MISS_REQ;
        end
      end
      HIT_RSP, MISS_RSP: begin
        if (from_cpu_cache_rsp_ready) state_d = IDLE;
      end
      MISS_REQ: begin
        if (from_mem_rd_req_ready) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (from_mem_rd_rsp_valid) begin
          beat_buf_d[cnt_q] = from_mem_rd_rsp_data;
          cnt_d             = cnt_q + 3'd1;
          if (from_mem_rd_rsp_last) begin
            valid_d[idx][vic_q] = 1'b1;
            if (vic_ptr_q) vptr_d[idx] = vptr_q[idx] + WAY_W'(1);
            rsp_data_d = line[{off, 5'b0} +: 32];
            state_d    = MISS_RSP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    rsp_data_q <= rsp_data_d;
    vic_q      <= vic_d;
    vic_ptr_q  <= vic_ptr_d;
    beat_buf_q <= beat_buf_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      vptr_q  <= vptr_d;
    end
  end

  // Tag/data arrays are plain storage and are never cleared by reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      data_mem[vic_q][idx] <= line;
      tag_mem[vic_q][idx]  <= tag;
    end
  end

  // Handshake outputs are masked by rst so nothing is offered during the reset cycle.
  assign to_cpu_inst_req_ready  = (state_q == IDLE) && !rst;
  assign to_cpu_cache_rsp_valid = ((state_q == HIT_RSP) || (state_q == MISS_RSP)) && !rst;
  assign to_cpu_cache_rsp_data  = rsp_data_q;
  assign to_mem_rd_req_valid    = (state_q == MISS_REQ) && !rst;
  assign to_mem_rd_req_addr     = {addr_q[31:5], 5'b0};
  assign to_mem_rd_rsp_ready    = (state_q == REFILL) && !rst;

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: transaction-level cache model predicts every output each cycle;
// directed scenarios pin the model with literal values, then a randomized fetch stream.
module tb_icache_ctrl;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, cpu_rsp_ready;
  logic [31:0] rsp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_last, mem_rsp_ready;
  logic [31:0] mem_rsp_data;

  icache_ctrl #(.TAG_W(24), .IDX_W(3), .WAYS(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cpu_inst_req_valid  (req_valid),
    .from_cpu_inst_req_addr   (req_addr),
    .to_cpu_inst_req_ready    (req_ready),
    .to_cpu_cache_rsp_valid   (rsp_valid),
    .to_cpu_cache_rsp_data    (rsp_data),
    .from_cpu_cache_rsp_ready (cpu_rsp_ready),
    .to_mem_rd_req_valid      (mem_req_valid),
    .to_mem_rd_req_addr       (mem_req_addr),
    .from_mem_rd_req_ready    (mem_req_ready),
    .from_mem_rd_rsp_valid    (mem_rsp_valid),
    .from_mem_rd_rsp_data     (mem_rsp_data),
    .from_mem_rd_rsp_last     (mem_rsp_last),
    .to_mem_rd_rsp_ready      (mem_rsp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cache model
  logic [23:0] mtag  [8][WAYS];
  bit          mvalid[8][WAYS];
  logic [31:0] mdata [8][WAYS][8];
  bit          mdk   [8][WAYS][8];
  int          mptr  [8];
  logic [31:0] mbuf  [8];
  bit          mbk   [8];

  // Per-cycle expectations
  bit          chk_en = 1'b0;
  bit          e_req_ready, e_rsp_valid, e_mem_valid, e_mem_rsp_ready, e_dchk;
  logic [31:0] e_rsp_data, e_mem_addr;

  // Observations of the DUT within the current fetch
  bit          saw_mem;
  int          lat, cyc_i, last_victim;
  logic [31:0] obs_data, obs_mem_addr;

  logic [23:0] tag_pool [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_req_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mem_valid));
      chk("mem_rsp_ready", 32'(mem_rsp_ready), 32'(e_mem_rsp_ready));
      if (e_rsp_valid && e_dchk) chk("rsp_data", rsp_data, e_rsp_data);
      if (e_mem_valid) chk("mem_req_addr", mem_req_addr, e_mem_addr);
    end
  end

  task automatic set_exp(input bit rr, input bit rv, input bit mv, input bit mrr);
    e_req_ready = rr; e_rsp_valid = rv; e_mem_valid = mv; e_mem_rsp_ready = mrr;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_req_valid) begin saw_mem = 1'b1; obs_mem_addr = mem_req_addr; end
    if (rsp_valid && lat < 0) begin lat = cyc_i; obs_data = rsp_data; end
    cyc_i++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b0; cpu_rsp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    set_exp(0, 0, 0, 0);
    repeat (n) tick();
    rst = 1'b0;
    model_reset();
    set_exp(1, 0, 0, 0);
  endtask

  task automatic rsp_stall(input int rs);
    for (int i = 0; i < rs; i++) begin
      cpu_rsp_ready = 1'b0;
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      tick();
    end
    cpu_rsp_ready = 1'b1; mem_rsp_valid = 1'b0; tick();
    cpu_rsp_ready = 1'b0;
  endtask

  // One complete fetch; ab >= 0 asserts rst after ab refill beats.
  task automatic fetch(input logic [31:0] a, input int rs, input int ms, input int nb,
                       input int ab, input bit fixd);
    int s, off, hw, vw, nrun;
    bit fromptr;
    logic [23:0] tg;
    logic [31:0] d;
    s = int'(a[7:5]); off = int'(a[4:2]); tg = a[31:8];
    hw = -1;
    for (int w = WAYS-1; w >= 0; w--) if (mvalid[s][w] && mtag[s][w] == tg) hw = w;
    saw_mem = 1'b0; lat = -1; cyc_i = 0; obs_data = '0; obs_mem_addr = '0;
    req_valid = 1'b1; req_addr = a; set_exp(1, 0, 0, 0); tick();
    req_valid = 1'b0; req_addr = $urandom; set_exp(0, 0, 0, 0); tick();
    if (hw >= 0) begin
      set_exp(0, 1, 0, 0); e_rsp_data = mdata[s][hw][off]; e_dchk = mdk[s][hw][off];
      rsp_stall(rs);
    end else begin
      vw = -1;
      for (int w = WAYS-1; w >= 0; w--) if (!mvalid[s][w]) vw = w;
      fromptr = (vw < 0);
      if (fromptr) vw = mptr[s];
      last_victim = vw;
      set_exp(0, 0, 1, 0); e_mem_addr = {a[31:5], 5'b0};
      for (int i = 0; i < ms; i++) begin
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
        mem_rsp_last = 1'($urandom_range(0, 1));
        tick();
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; tick();
      mem_req_ready = 1'b0; set_exp(0, 0, 0, 1);
      for (int w = 0; w < 8; w++) mbk[w] = 1'b0;
      nrun = (ab >= 0) ? ab : nb;
      for (int b = 0; b < nrun; b++) begin
        repeat ($urandom_range(0, 2)) begin
          mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; tick();
        end
        d = fixd ? (32'hD000_0000 + 32'(b)) : $urandom;
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_last = (ab < 0) && (b == nb - 1);
        mbuf[b % 8] = d; mbk[b % 8] = 1'b1;
        tick();
      end
      mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
      if (ab >= 0) begin
        rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_last = 1'b1; mem_rsp_data = $urandom;
        set_exp(0, 0, 0, 0); tick();
        rst = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        model_reset(); set_exp(1, 0, 0, 0);
        return;
      end
      mtag[s][vw] = tg; mvalid[s][vw] = 1'b1;
      for (int w = 0; w < 8; w++) begin mdata[s][vw][w] = mbuf[w]; mdk[s][vw][w] = mbk[w]; end
      if (fromptr) mptr[s] = (mptr[s] + 1) % WAYS;
      set_exp(0, 1, 0, 0); e_rsp_data = mbuf[off]; e_dchk = mbk[off];
      rsp_stall(rs);
    end
    set_exp(1, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_addr = '0; mem_rsp_data = '0; e_rsp_data = '0; e_mem_addr = '0; e_dchk = 1'b0;
    last_victim = -1;
    for (int i = 0; i < 6; i++) tag_pool[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) mbk[i] = 1'b0;
    chk_en = 1'b1;
    do_reset(2);
    tick();

    // Cold miss: line 0x1020 refilled with D0..D7, word 1 returned
    fetch(32'h0000_1024, 3, 5, 8, -1, 1'b1);
    chk("cold_saw_mem", 32'(saw_mem), 32'd1);
    chk("cold_mem_addr", obs_mem_addr, 32'h0000_1020);
    chk("cold_rsp_data", obs_data, 32'hD000_0001);
    chk("cold_model_way0_valid", 32'(mvalid[1][0]), 32'd1);

    // Hit with 10 stall cycles; latency from accept is 2
    fetch(32'h0000_1028, 10, 0, 8, -1, 1'b0);
    chk("hit_no_mem", 32'(saw_mem), 32'd0);
    chk("hit_latency", 32'(lat), 32'd2);
    chk("hit_rsp_data", obs_data, 32'hD000_0002);

    // Replacement: five distinct tags into set 1
    do_reset(1);
    for (int t = 1; t <= 5; t++) begin
      fetch((32'(t) << 8) | 32'h20, 1, (t == 3) ? 5 : 0, 8, -1, 1'b0);
      if (t == 4) chk("repl_fill4_way", 32'(last_victim), 32'd3);
    end
    chk("repl_evict_way", 32'(last_victim), 32'd0);
    chk("repl_ptr", 32'(mptr[1]), 32'd1);
    fetch(32'h0000_0120, 0, 0, 8, -1, 1'b0);
    chk("refetch_evicted_miss", 32'(saw_mem), 32'd1);
    chk("refetch_victim", 32'(last_victim), 32'd1);
    fetch(32'h0000_0524, 0, 0, 8, -1, 1'b0);
    chk("tag5_still_hits", 32'(saw_mem), 32'd0);

    // Reset after 4 refill beats discards everything
    do_reset(1);
    fetch(32'h0000_1024, 0, 0, 8, -1, 1'b0);
    fetch(32'h0000_2024, 0, 0, 8, 4, 1'b0);
    tick();
    fetch(32'h0000_1024, 0, 0, 8, -1, 1'b0);
    chk("post_abort_remiss", 32'(saw_mem), 32'd1);
    chk("post_abort_addr", obs_mem_addr, 32'h0000_1020);

    // Randomized fetch stream
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int nb, ab, r;
      a  = {tag_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      r  = int'($urandom_range(0, 9));
      nb = (r == 7) ? int'($urandom_range(1, 7)) : (r == 8) ? int'($urandom_range(9, 12)) : 8;
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), nb, ab, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
